// File: rtl/dm_outer_multihart.sv
// Outer debug-module register block for multiple harts: DMCONTROL/HAWINDOW over DMI,
// per-hart halt requests, reset-halt masks and a registered hand-off to the inner domain.
module dm_outer_multihart #(
    parameter int NHARTS = 4,
    parameter int HSW    = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dmi_req_valid,
    output logic              dmi_req_ready,
    input  logic              dmi_req_write,
    input  logic [6:0]        dmi_req_addr,
    input  logic [31:0]       dmi_req_data,
    output logic              dmi_rsp_valid,
    input  logic              dmi_rsp_ready,
    output logic [31:0]       dmi_rsp_data,
    output logic              ctrl_dmactive,
    input  logic              ctrl_dmactive_ack,
    output logic              inner_valid,
    input  logic              inner_ready,
    output logic [NHARTS-1:0] inner_resumereq,
    output logic [NHARTS-1:0] inner_ackhavereset,
    output logic [NHARTS-1:0] inner_hrmask,
    input  logic [NHARTS-1:0] hg_debug_int,
    output logic [NHARTS-1:0] debug_int
);
    localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
    localparam logic [6:0] ADDR_HAWINDOW  = 7'h15;

    logic              dmactive, dmactive_n;
    logic              ndmreset, ndmreset_n;
    logic              hasel, hasel_n;
    logic [HSW-1:0]    hartsel, hartsel_n;
    logic [NHARTS-1:0] haltreq, haltreq_n;
    logic [NHARTS-1:0] hrmask, hrmask_n;
    logic [NHARTS-1:0] hawindow, hawindow_n;
    logic [NHARTS-1:0] resume_p, resume_p_n;
    logic [NHARTS-1:0] ack_p, ack_p_n;
    logic              ivalid, ivalid_n;
    logic              rsp_valid, rsp_valid_n;
    logic [31:0]       rsp_data, rsp_data_n;

    logic              accept;
    logic              wr_ctrl;
    logic              wr_hawindow;
    logic [HSW-1:0]    w_hartsel;
    logic [NHARTS-1:0] sel;
    logic              sel_haltreq;
    logic [31:0]       rd_data;
    logic              unused_data;

    assign unused_data = ^dmi_req_data;

    always_comb begin
        accept      = dmi_req_valid & dmi_req_ready;
        wr_ctrl     = accept & dmi_req_write & (dmi_req_addr == ADDR_DMCONTROL);
        wr_hawindow = accept & dmi_req_write & (dmi_req_addr == ADDR_HAWINDOW);
        w_hartsel   = dmi_req_data[16 +: HSW];
        sel         = '0;
        sel_haltreq = 1'b0;
        for (int unsigned i = 0; i < NHARTS; i++) begin
            sel[i] = (w_hartsel == HSW'(i)) | (dmi_req_data[26] & hawindow[i]);
            if (hartsel == HSW'(i)) sel_haltreq = haltreq[i];
        end
    end

    // Read data is captured from pre-write state at the accept edge.
    always_comb begin
        rd_data = '0;
        if (!dmi_req_write) begin
            case (dmi_req_addr)
                ADDR_DMCONTROL: begin
                    rd_data[31]          = sel_haltreq;
                    rd_data[26]          = hasel;
                    rd_data[16 +: HSW]   = hartsel;
                    rd_data[1]           = ndmreset;
                    rd_data[0]           = dmactive & ctrl_dmactive_ack;
                end
                ADDR_HAWINDOW: rd_data[NHARTS-1:0] = hawindow;
                default:       rd_data = '0;
            endcase
        end
    end

    always_comb begin
        dmactive_n  = dmactive;
        ndmreset_n  = ndmreset;
        hasel_n     = hasel;
        hartsel_n   = hartsel;
        haltreq_n   = haltreq;
        hrmask_n    = hrmask;
        hawindow_n  = hawindow;
        resume_p_n  = resume_p;
        ack_p_n     = ack_p;
        ivalid_n    = ivalid;
        rsp_valid_n = rsp_valid;
        rsp_data_n  = rsp_data;

        // Handshake clears first so a same-cycle write contributes only its own bits.
        if (ivalid && inner_ready) begin
            resume_p_n = '0;
            ack_p_n    = '0;
            ivalid_n   = 1'b0;
        end

        if (wr_hawindow) hawindow_n = dmi_req_data[NHARTS-1:0];

        if (wr_ctrl) begin
            if (!dmi_req_data[0]) begin
                dmactive_n = 1'b0;
                ndmreset_n = 1'b0;
                hasel_n    = 1'b0;
                hartsel_n  = '0;
                haltreq_n  = '0;
                hrmask_n   = '0;
                hawindow_n = '0;
                resume_p_n = '0;
                ack_p_n    = '0;
                ivalid_n   = 1'b0;
            end else if (!dmactive) begin
                dmactive_n = 1'b1;
            end else begin
                ndmreset_n = dmi_req_data[1];
                hasel_n    = dmi_req_data[26];
                hartsel_n  = w_hartsel;
                ivalid_n   = 1'b1;
                for (int unsigned i = 0; i < NHARTS; i++) begin
                    if (sel[i]) begin
                        haltreq_n[i] = dmi_req_data[31];
                        if (dmi_req_data[3]) hrmask_n[i] = 1'b1;
                        if (dmi_req_data[2]) hrmask_n[i] = 1'b0;
                        if (dmi_req_data[30] && !dmi_req_data[31]) resume_p_n[i] = 1'b1;
                        if (dmi_req_data[28]) ack_p_n[i] = 1'b1;
                    end
                end
            end
        end

        if (accept) begin
            rsp_valid_n = 1'b1;
            rsp_data_n  = rd_data;
        end else if (dmi_rsp_ready) begin
            rsp_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dmactive  <= 1'b0;
            ndmreset  <= 1'b0;
            hasel     <= 1'b0;
            hartsel   <= '0;
            haltreq   <= '0;
            hrmask    <= '0;
            hawindow  <= '0;
            resume_p  <= '0;
            ack_p     <= '0;
            ivalid    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            dmactive  <= dmactive_n;
            ndmreset  <= ndmreset_n;
            hasel     <= hasel_n;
            hartsel   <= hartsel_n;
            haltreq   <= haltreq_n;
            hrmask    <= hrmask_n;
            hawindow  <= hawindow_n;
            resume_p  <= resume_p_n;
            ack_p     <= ack_p_n;
            ivalid    <= ivalid_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
        end
    end

    assign dmi_req_ready      = ~rsp_valid | dmi_rsp_ready;
    assign dmi_rsp_valid      = rsp_valid;
    assign dmi_rsp_data       = rsp_data;
    assign ctrl_dmactive      = dmactive;
    assign inner_valid        = ivalid;
    assign inner_resumereq    = resume_p;
    assign inner_ackhavereset = ack_p;
    assign inner_hrmask       = hrmask;
    assign debug_int          = haltreq | hg_debug_int;

endmodule

// File: tb/tb_dm_outer_multihart.sv
// Scoreboard bench for dm_outer_multihart: DMI responses are checked by monitors against
// queued expectations; side-band outputs are checked directly after each step.
module tb_dm_outer_multihart;
    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1, ack = 1'b1, inner_ready = 1'b1;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic        req_ready, rsp_valid, dmactive, inner_valid;
    logic [31:0] rsp_data;
    logic [3:0]  resumereq, ackhavereset, hrmask, hg = 4'b0010, dbg;

    logic        req_valid3 = 1'b0, req_write3 = 1'b0, rsp_ready3 = 1'b1, inner_ready3 = 1'b1;
    logic [6:0]  req_addr3 = '0;
    logic [31:0] req_data3 = '0;
    logic        req_ready3, rsp_valid3, dmactive3, inner_valid3;
    logic [31:0] rsp_data3;
    logic [2:0]  resumereq3, ackhavereset3, hrmask3, dbg3;
    logic [2:0]  hg3 = '0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp3_q[$];

    always #5 clock = ~clock;

    dm_outer_multihart #(.NHARTS(4)) dut (
        .clock(clock), .reset(reset),
        .dmi_req_valid(req_valid), .dmi_req_ready(req_ready), .dmi_req_write(req_write),
        .dmi_req_addr(req_addr), .dmi_req_data(req_data),
        .dmi_rsp_valid(rsp_valid), .dmi_rsp_ready(rsp_ready), .dmi_rsp_data(rsp_data),
        .ctrl_dmactive(dmactive), .ctrl_dmactive_ack(ack),
        .inner_valid(inner_valid), .inner_ready(inner_ready),
        .inner_resumereq(resumereq), .inner_ackhavereset(ackhavereset), .inner_hrmask(hrmask),
        .hg_debug_int(hg), .debug_int(dbg)
    );

    dm_outer_multihart #(.NHARTS(3)) dut3 (
        .clock(clock), .reset(reset),
        .dmi_req_valid(req_valid3), .dmi_req_ready(req_ready3), .dmi_req_write(req_write3),
        .dmi_req_addr(req_addr3), .dmi_req_data(req_data3),
        .dmi_rsp_valid(rsp_valid3), .dmi_rsp_ready(rsp_ready3), .dmi_rsp_data(rsp_data3),
        .ctrl_dmactive(dmactive3), .ctrl_dmactive_ack(1'b1),
        .inner_valid(inner_valid3), .inner_ready(inner_ready3),
        .inner_resumereq(resumereq3), .inner_ackhavereset(ackhavereset3), .inner_hrmask(hrmask3),
        .hg_debug_int(hg3), .debug_int(dbg3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitors: pop one expectation per completed DMI response.
    always @(negedge clock) begin
        if (rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got 0x%08h expected no response", rsp_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rsp_data !== e) begin
                    failures++;
                    $display("FAIL rsp_data: got 0x%08h expected 0x%08h", rsp_data, e);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (rsp_valid3 && rsp_ready3) begin
            checks++;
            if (exp3_q.size() == 0) begin
                failures++;
                $display("FAIL rsp3_unexpected: got 0x%08h expected no response", rsp_data3);
            end else begin
                logic [31:0] e;
                e = exp3_q.pop_front();
                if (rsp_data3 !== e) begin
                    failures++;
                    $display("FAIL rsp3_data: got 0x%08h expected 0x%08h", rsp_data3, e);
                end
            end
        end
    end

    task automatic dmi(input logic wr, input logic [6:0] a, input logic [31:0] d, input logic [31:0] e);
        bit ok = 1'b0;
        req_write = wr; req_addr = a; req_data = d; req_valid = 1'b1;
        exp_q.push_back(e);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clock);
            ok = req_ready;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL req_timeout: got ready=0 expected ready=1 addr=0x%02h", a);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic dmi3(input logic wr, input logic [6:0] a, input logic [31:0] d, input logic [31:0] e);
        bit ok = 1'b0;
        req_write3 = wr; req_addr3 = a; req_data3 = d; req_valid3 = 1'b1;
        exp3_q.push_back(e);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clock);
            ok = req_ready3;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL req3_timeout: got ready=0 expected ready=1 addr=0x%02h", a);
        end
        @(posedge clock); #1;
        req_valid3 = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_inner_valid", 32'(inner_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_dmactive", 32'(dmactive), 32'h0);
        chk("rst_debug_int", 32'(dbg), 32'h2);
        cyc(); reset = 1'b0; hg = '0;
        cyc();

        dmi(1, 7'h10, 32'h0000_0001, 32'h0);
        dmi(1, 7'h10, 32'h8002_0001, 32'h0);
        chk("haltreq_hart2", 32'(dbg), 32'h4);
        chk("ctrl_dmactive", 32'(dmactive), 32'h1);
        hg = 4'b1000; #1;
        chk("hg_or", 32'(dbg), 32'hC);
        hg = '0;
        dmi(0, 7'h10, 32'h0, 32'h8002_0001);
        dmi(1, 7'h20, 32'hFFFF_FFFF, 32'h0);
        dmi(0, 7'h20, 32'h0, 32'h0);
        dmi(0, 7'h14, 32'h0, 32'h0);
        dmi(1, 7'h15, 32'h0000_000B, 32'h0);
        dmi(0, 7'h15, 32'h0, 32'h0000_000B);

        inner_ready = 1'b0;
        dmi(1, 7'h10, 32'h4400_0001, 32'h0);
        chk("resume_valid", 32'(inner_valid), 32'h1);
        chk("resume_mask", 32'(resumereq), 32'hB);
        chk("resume_no_ack", 32'(ackhavereset), 32'h0);
        chk("resume_keeps_halt2", 32'(dbg), 32'h4);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("hold_valid", 32'(inner_valid), 32'h1);
            chk("hold_resume", 32'(resumereq), 32'hB);
        end
        inner_ready = 1'b1;
        cyc();
        chk("drain_valid", 32'(inner_valid), 32'h0);
        chk("drain_resume", 32'(resumereq), 32'h0);

        inner_ready = 1'b0;
        dmi(1, 7'h10, 32'h0400_0001, 32'h0);
        chk("plain_write_valid", 32'(inner_valid), 32'h1);
        inner_ready = 1'b1;
        dmi(1, 7'h10, 32'h1000_0001, 32'h0);
        chk("overlap_valid", 32'(inner_valid), 32'h1);
        chk("overlap_ack", 32'(ackhavereset), 32'h1);
        chk("overlap_resume", 32'(resumereq), 32'h0);
        cyc();
        chk("overlap_drain", 32'(inner_valid), 32'h0);

        dmi(1, 7'h10, 32'h0400_0009, 32'h0);
        chk("hrmask_set", 32'(hrmask), 32'hB);
        dmi(1, 7'h10, 32'h0000_000D, 32'h0);
        chk("hrmask_clr_wins", 32'(hrmask), 32'hA);

        inner_ready = 1'b0;
        dmi(1, 7'h10, 32'hC400_0001, 32'h0);
        chk("halt_window", 32'(dbg), 32'hF);
        chk("resume_suppressed", 32'(resumereq), 32'h0);
        inner_ready = 1'b1;
        cyc();

        rsp_ready = 1'b0;
        dmi(0, 7'h10, 32'h0, 32'h8400_0001);
        chk("stall_ready0", 32'(req_ready), 32'h0);
        cyc(); cyc();
        chk("stall_ready1", 32'(req_ready), 32'h0);
        chk("stall_rsp_held", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        dmi(1, 7'h10, 32'h0, 32'h0);
        chk("deact_haltreq", 32'(dbg), 32'h0);
        chk("deact_hrmask", 32'(hrmask), 32'h0);
        chk("deact_dmactive", 32'(dmactive), 32'h0);
        dmi(0, 7'h15, 32'h0, 32'h0);
        dmi(0, 7'h10, 32'h0, 32'h0);
        dmi(1, 7'h10, 32'h8000_0001, 32'h0);
        chk("activate_only", 32'(dbg), 32'h0);
        chk("activate_no_inner", 32'(inner_valid), 32'h0);
        dmi(0, 7'h10, 32'h0, 32'h0000_0001);

        dmi3(1, 7'h10, 32'h0000_0001, 32'h0);
        dmi3(1, 7'h10, 32'h8003_0001, 32'h0);
        chk("n3_oob_halt", 32'(dbg3), 32'h0);
        dmi3(0, 7'h10, 32'h0, 32'h0003_0001);
        dmi3(1, 7'h15, 32'h0000_00FF, 32'h0);
        dmi3(0, 7'h15, 32'h0, 32'h0000_0007);

        rsp_ready = 1'b0; inner_ready = 1'b0;
        dmi(1, 7'h10, 32'h1000_0001, 32'h0);
        chk("pre_reset_rsp", 32'(rsp_valid), 32'h1);
        chk("pre_reset_inner", 32'(inner_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_rsp", 32'(rsp_valid), 32'h0);
        chk("midrst_inner", 32'(inner_valid), 32'h0);
        chk("midrst_ack", 32'(ackhavereset), 32'h0);
        chk("midrst_dmactive", 32'(dmactive), 32'h0);
        exp_q.delete();
        cyc();
        reset = 1'b0; rsp_ready = 1'b1; inner_ready = 1'b1;
        repeat (5) cyc();
        chk("post_rst_req_ready", 32'(req_ready), 32'h1);
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("queue3_drained", 32'(exp3_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
